// File: rtl/rast_dispatch_pkg.sv
// Shared constants, reset values and FSM encoding for the rasterizer dispatch block.
package rast_params;
    localparam int SIGFIG     = 16;
    localparam int VERTS      = 3;
    localparam int AXIS       = 2;
    localparam int COLORS     = 3;
    localparam int NREQ       = 4;

    localparam int PIPES_BOX  = 2;
    localparam int PIPES_ITER = 3;
    localparam int PIPES_HASH = 1;
    localparam int PIPES_SAMP = 2;
    // Quiet window long enough for every downstream pipe to empty, plus margin.
    localparam int RAST_DRAIN = PIPES_BOX + PIPES_ITER + PIPES_HASH + PIPES_SAMP + 8;

    // Index 0 = width, index 1 = height.
    localparam logic [1:0][SIGFIG-1:0] DEF_SCREEN    = {16'd480, 16'd640};
    localparam logic [3:0]             DEF_SUBSAMPLE = 4'd4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CFG   = 2'd2
    } disp_state_e;
endpackage

// File: rtl/rast_dispatch_if.sv
// Triangle requester bundle: requesters drive data/valid, dispatch returns one-hot ready.
interface rast_dispatch_if #(
    parameter int NREQ   = rast_params::NREQ,
    parameter int VERTS  = rast_params::VERTS,
    parameter int AXIS   = rast_params::AXIS,
    parameter int COLORS = rast_params::COLORS,
    parameter int SIGFIG = rast_params::SIGFIG
);
    logic signed [NREQ-1:0][VERTS-1:0][AXIS-1:0][SIGFIG-1:0] req_tri_S;
    logic        [NREQ-1:0][COLORS-1:0][SIGFIG-1:0]          req_color_U;
    logic        [NREQ-1:0]                                  req_valid;
    logic        [NREQ-1:0]                                  req_ready;

    modport master (output req_tri_S, output req_color_U, output req_valid, input req_ready);
    modport slave  (input req_tri_S, input req_color_U, input req_valid, output req_ready);
endinterface

// File: rtl/rast_dispatch_rr_arb.sv
// Round-robin arbiter: priority starts at the pointer and ascends modulo NREQ.
module rr_arb #(
    parameter int NREQ = rast_params::NREQ
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    output logic [NREQ-1:0] grant
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Pick the first requester at or after the pointer; next pointer is one past the winner.
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % NREQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_d      = (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
            end
        end
        if (!adv) begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/rast_dispatch.sv
// Dispatches triangles from NREQ requesters into a single rasterizer input register and
// sequences screen/subsample reconfiguration only after the rasterizer has gone quiet.
//
// state    | meaning
// ST_RUN   | normal dispatch, grants allowed when no config is pending
// ST_DRAIN | config pending, wait DRAIN_CYCLES consecutive quiet cycles
// ST_CFG   | one-cycle config apply, cfg_ready asserted
module rast_dispatch #(
    parameter int SIGFIG       = rast_params::SIGFIG,
    parameter int VERTS        = rast_params::VERTS,
    parameter int AXIS         = rast_params::AXIS,
    parameter int COLORS       = rast_params::COLORS,
    parameter int NREQ         = rast_params::NREQ,
    parameter int DRAIN_CYCLES = rast_params::RAST_DRAIN
) (
    input  logic                                      clk,
    input  logic                                      rst,
    rast_dispatch_if.slave                            req_if,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S,
    output logic        [COLORS-1:0][SIGFIG-1:0]      color_R10U,
    output logic                                      validTri_R10H,
    input  logic                                      halt_RnnnnL,
    input  logic signed [1:0][SIGFIG-1:0]             cfg_screen_S,
    input  logic        [3:0]                         cfg_subSample_U,
    input  logic                                      cfg_valid,
    output logic                                      cfg_ready,
    output logic        [1:0][SIGFIG-1:0]             screen_RnnnnS,
    output logic        [3:0]                         subSample_RnnnnU,
    output logic        [31:0]                        tri_count
);
    import rast_params::*;

    localparam int QW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    disp_state_e                               state_q, state_d;
    logic [QW-1:0]                             quiet_q, quiet_d;
    logic                                      valid_q, valid_d;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
    logic [COLORS-1:0][SIGFIG-1:0]             color_q, color_d;
    logic [1:0][SIGFIG-1:0]                    screen_q, screen_d;
    logic [3:0]                                sub_q, sub_d;
    logic                                      cfg_ready_q, cfg_ready_d;
    logic [31:0]                               count_q, count_d;

    logic            load_en;
    logic            xfer;
    logic [NREQ-1:0] grant;

    // rst gates load_en so no requester sees ready while the block is held in reset.
    assign load_en = rst && (state_q == ST_RUN) && !cfg_valid && (!valid_q || halt_RnnnnL);
    assign xfer    = valid_q && halt_RnnnnL;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_if.req_valid & {NREQ{load_en}}),
        .adv   (load_en),
        .grant (grant)
    );

    assign req_if.req_ready = grant;

    // Next-state for output register, counters, config shadow and the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        quiet_d     = quiet_q;
        valid_d     = valid_q;
        tri_d       = tri_q;
        color_d     = color_q;
        screen_d    = screen_q;
        sub_d       = sub_q;
        cfg_ready_d = 1'b0;
        count_d     = count_q + 32'(xfer);

        if (load_en) begin
            valid_d = |grant;
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i]) begin
                    tri_d   = req_if.req_tri_S[i];
                    color_d = req_if.req_color_U[i];
                end
            end
        end else if (xfer) begin
            // A held triangle still drains while config is pending.
            valid_d = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                quiet_d = '0;
                if (cfg_valid) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!cfg_valid) begin
                    state_d = ST_RUN;
                    quiet_d = '0;
                end else if (valid_q || !halt_RnnnnL) begin
                    quiet_d = '0;
                end else if (quiet_q == QW'(DRAIN_CYCLES - 1)) begin
                    state_d     = ST_CFG;
                    quiet_d     = '0;
                    cfg_ready_d = 1'b1;
                end else begin
                    quiet_d = quiet_q + 1'b1;
                end
            end
            ST_CFG: begin
                screen_d = cfg_screen_S;
                sub_d    = cfg_subSample_U;
                quiet_d  = '0;
                state_d  = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                quiet_d = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            quiet_q     <= '0;
            valid_q     <= 1'b0;
            tri_q       <= '0;
            color_q     <= '0;
            screen_q    <= (2 * SIGFIG)'(DEF_SCREEN);
            sub_q       <= DEF_SUBSAMPLE;
            cfg_ready_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            quiet_q     <= quiet_d;
            valid_q     <= valid_d;
            tri_q       <= tri_d;
            color_q     <= color_d;
            screen_q    <= screen_d;
            sub_q       <= sub_d;
            cfg_ready_q <= cfg_ready_d;
            count_q     <= count_d;
        end
    end

    assign tri_R10S         = tri_q;
    assign color_R10U       = color_q;
    assign validTri_R10H    = valid_q;
    assign cfg_ready        = cfg_ready_q;
    assign screen_RnnnnS    = screen_q;
    assign subSample_RnnnnU = sub_q;
    assign tri_count        = count_q;
endmodule

// File: tb/tb_rast_dispatch.sv
module tb_rast_dispatch;
    localparam int S = 16;
    localparam int V = 3;
    localparam int A = 2;
    localparam int C = 3;
    localparam int N = 4;
    localparam int D = 4;

    localparam logic [31:0] DEF_SCR  = 32'h01E0_0280;
    localparam logic [3:0]  DEF_SUB  = 4'd4;
    localparam logic [31:0] NEW_SCR  = 32'h0438_0780;
    localparam logic [3:0]  NEW_SUB  = 4'd9;
    localparam logic [31:0] NEW2_SCR = 32'h0258_0320;
    localparam logic [3:0]  NEW2_SUB = 4'd2;

    logic clk;
    logic rst;
    logic signed [V-1:0][A-1:0][S-1:0] tri_R10S;
    logic [C-1:0][S-1:0]               color_R10U;
    logic                              validTri_R10H;
    logic                              halt_RnnnnL;
    logic signed [1:0][S-1:0]          cfg_screen_S;
    logic [3:0]                        cfg_subSample_U;
    logic                              cfg_valid;
    logic                              cfg_ready;
    logic [1:0][S-1:0]                 screen_RnnnnS;
    logic [3:0]                        subSample_RnnnnU;
    logic [31:0]                       tri_count;

    int errors = 0;
    int checks = 0;

    rast_dispatch_if #(.NREQ(N), .VERTS(V), .AXIS(A), .COLORS(C), .SIGFIG(S)) ifc ();

    rast_dispatch #(
        .SIGFIG(S), .VERTS(V), .AXIS(A), .COLORS(C), .NREQ(N), .DRAIN_CYCLES(D)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_if           (ifc.slave),
        .tri_R10S         (tri_R10S),
        .color_R10U       (color_R10U),
        .validTri_R10H    (validTri_R10H),
        .halt_RnnnnL      (halt_RnnnnL),
        .cfg_screen_S     (cfg_screen_S),
        .cfg_subSample_U  (cfg_subSample_U),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .screen_RnnnnS    (screen_RnnnnS),
        .subSample_RnnnnU (subSample_RnnnnU),
        .tri_count        (tri_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [V*A*S-1:0] tri_pat(input int i);
        logic [V*A*S-1:0] r;
        r = '0;
        for (int e = 0; e < V * A; e++) r[e*S +: S] = S'((i + 1) * 1000 - e * 333);
        return r;
    endfunction

    function automatic logic [C*S-1:0] color_pat(input int i);
        logic [C*S-1:0] r;
        r = '0;
        for (int c = 0; c < C; c++) r[c*S +: S] = S'(i * 4096 + c * 5 + 9);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        halt_RnnnnL = 1'b1;
        cfg_valid = 1'b0;
        cfg_screen_S = '0;
        cfg_subSample_U = '0;
        for (int i = 0; i < N; i++) begin
            ifc.req_tri_S[i]   = tri_pat(i);
            ifc.req_color_U[i] = color_pat(i);
        end
        ifc.req_valid = 4'hF;
        #2 rst = 1'b0;
        #1;
        checks++; if (validTri_R10H !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", validTri_R10H); end
        checks++; if (tri_R10S !== '0) begin errors++; $display("FAIL rst_tri got %h exp 0", tri_R10S); end
        checks++; if (color_R10U !== '0) begin errors++; $display("FAIL rst_color got %h exp 0", color_R10U); end
        checks++; if (tri_count !== 32'd0) begin errors++; $display("FAIL rst_count got %h exp 0", tri_count); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_cfg_ready got %b exp 0", cfg_ready); end
        checks++; if (screen_RnnnnS !== DEF_SCR) begin errors++; $display("FAIL rst_screen got %h exp %h", screen_RnnnnS, DEF_SCR); end
        checks++; if (subSample_RnnnnU !== DEF_SUB) begin errors++; $display("FAIL rst_sub got %h exp %h", subSample_RnnnnU, DEF_SUB); end
        checks++; if (ifc.req_ready !== 4'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0000", ifc.req_ready); end
        ifc.req_valid = 4'h0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_round_robin();
        ifc.req_valid = 4'hF;
        halt_RnnnnL = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (ifc.req_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", k, ifc.req_ready, 4'(1 << (k % 4))); end
            tick();
            checks++; if (validTri_R10H !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %b exp 1", k, validTri_R10H); end
            checks++; if (tri_R10S !== tri_pat(k % 4)) begin errors++; $display("FAIL rr_tri[%0d] got %h exp %h", k, tri_R10S, tri_pat(k % 4)); end
            checks++; if (color_R10U !== color_pat(k % 4)) begin errors++; $display("FAIL rr_color[%0d] got %h exp %h", k, color_R10U, color_pat(k % 4)); end
            checks++; if (tri_count !== 32'(k)) begin errors++; $display("FAIL rr_count[%0d] got %0d exp %0d", k, tri_count, k); end
        end
        ifc.req_valid = 4'h0;
        #1;
        checks++; if (ifc.req_ready !== 4'b0) begin errors++; $display("FAIL rr_idle_ready got %b exp 0000", ifc.req_ready); end
        tick();
        checks++; if (validTri_R10H !== 1'b0) begin errors++; $display("FAIL rr_empty_valid got %b exp 0", validTri_R10H); end
        checks++; if (tri_count !== 32'd5) begin errors++; $display("FAIL rr_final_count got %0d exp 5", tri_count); end
    endtask

    task automatic test_stall();
        ifc.req_valid = 4'hF;
        #1;
        checks++; if (ifc.req_ready !== 4'b0010) begin errors++; $display("FAIL stall_grant got %b exp 0010", ifc.req_ready); end
        tick();
        halt_RnnnnL = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (ifc.req_ready !== 4'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b exp 0000", k, ifc.req_ready); end
            tick();
            checks++; if (validTri_R10H !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", k, validTri_R10H); end
            checks++; if (tri_R10S !== tri_pat(1)) begin errors++; $display("FAIL stall_tri[%0d] got %h exp %h", k, tri_R10S, tri_pat(1)); end
            checks++; if (tri_count !== 32'd5) begin errors++; $display("FAIL stall_count[%0d] got %0d exp 5", k, tri_count); end
        end
        halt_RnnnnL = 1'b1;
        #1;
        checks++; if (ifc.req_ready !== 4'b0100) begin errors++; $display("FAIL stall_resume_grant got %b exp 0100", ifc.req_ready); end
        tick();
        checks++; if (tri_count !== 32'd6) begin errors++; $display("FAIL stall_resume_count got %0d exp 6", tri_count); end
        checks++; if (tri_R10S !== tri_pat(2)) begin errors++; $display("FAIL stall_resume_tri got %h exp %h", tri_R10S, tri_pat(2)); end
        ifc.req_valid = 4'h0;
        tick();
        checks++; if (tri_count !== 32'd7) begin errors++; $display("FAIL stall_drain_count got %0d exp 7", tri_count); end
    endtask

    task automatic test_cfg();
        cfg_screen_S = {16'sd1080, 16'sd1920};
        cfg_subSample_U = NEW_SUB;
        cfg_valid = 1'b1;
        ifc.req_valid = 4'b1010;
        #1;
        checks++; if (ifc.req_ready !== 4'b0) begin errors++; $display("FAIL cfg_block_ready got %b exp 0000", ifc.req_ready); end
        for (int j = 1; j <= D; j++) begin
            tick();
            checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_early_ready[%0d] got %b exp 0", j, cfg_ready); end
            checks++; if (ifc.req_ready !== 4'b0) begin errors++; $display("FAIL cfg_drain_grant[%0d] got %b exp 0000", j, ifc.req_ready); end
        end
        tick();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready got %b exp 1", cfg_ready); end
        checks++; if (screen_RnnnnS !== DEF_SCR) begin errors++; $display("FAIL cfg_screen_early got %h exp %h", screen_RnnnnS, DEF_SCR); end
        cfg_valid = 1'b0;
        tick();
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_pulse got %b exp 0", cfg_ready); end
        checks++; if (screen_RnnnnS !== NEW_SCR) begin errors++; $display("FAIL cfg_screen got %h exp %h", screen_RnnnnS, NEW_SCR); end
        checks++; if (subSample_RnnnnU !== NEW_SUB) begin errors++; $display("FAIL cfg_sub got %h exp %h", subSample_RnnnnU, NEW_SUB); end
        checks++; if (ifc.req_ready !== 4'b1000) begin errors++; $display("FAIL cfg_resume_grant got %b exp 1000", ifc.req_ready); end
        tick();
        checks++; if (tri_R10S !== tri_pat(3)) begin errors++; $display("FAIL cfg_resume_tri got %h exp %h", tri_R10S, tri_pat(3)); end
        ifc.req_valid = 4'h0;
        tick();
        checks++; if (tri_count !== 32'd8) begin errors++; $display("FAIL cfg_count got %0d exp 8", tri_count); end
    endtask

    task automatic test_drain_halt();
        ifc.req_valid = 4'b0001;
        #1;
        checks++; if (ifc.req_ready !== 4'b0001) begin errors++; $display("FAIL dh_grant got %b exp 0001", ifc.req_ready); end
        tick();
        ifc.req_valid = 4'h0;
        halt_RnnnnL = 1'b0;
        cfg_screen_S = {16'sd600, 16'sd800};
        cfg_subSample_U = NEW2_SUB;
        cfg_valid = 1'b1;
        tick();
        checks++; if (validTri_R10H !== 1'b1) begin errors++; $display("FAIL dh_held_valid got %b exp 1", validTri_R10H); end
        halt_RnnnnL = 1'b1;
        tick();
        checks++; if (tri_count !== 32'd9) begin errors++; $display("FAIL dh_count got %0d exp 9", tri_count); end
        checks++; if (validTri_R10H !== 1'b0) begin errors++; $display("FAIL dh_empty got %b exp 0", validTri_R10H); end
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL dh_quiet_ready[%0d] got %b exp 0", j, cfg_ready); end
        end
        halt_RnnnnL = 1'b0;
        tick();
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL dh_restart_ready got %b exp 0", cfg_ready); end
        halt_RnnnnL = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL dh_requiet_ready[%0d] got %b exp 0", j, cfg_ready); end
        end
        tick();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL dh_cfg_ready got %b exp 1", cfg_ready); end
        cfg_valid = 1'b0;
        tick();
        checks++; if (screen_RnnnnS !== NEW2_SCR) begin errors++; $display("FAIL dh_screen got %h exp %h", screen_RnnnnS, NEW2_SCR); end
        checks++; if (subSample_RnnnnU !== NEW2_SUB) begin errors++; $display("FAIL dh_sub got %h exp %h", subSample_RnnnnU, NEW2_SUB); end
    endtask

    task automatic test_cfg_abort();
        cfg_screen_S = {16'sd222, 16'sd111};
        cfg_subSample_U = 4'd15;
        cfg_valid = 1'b1;
        tick();
        tick();
        cfg_valid = 1'b0;
        tick();
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %b exp 0", cfg_ready); end
        tick();
        checks++; if (screen_RnnnnS !== NEW2_SCR) begin errors++; $display("FAIL abort_screen got %h exp %h", screen_RnnnnS, NEW2_SCR); end
        checks++; if (subSample_RnnnnU !== NEW2_SUB) begin errors++; $display("FAIL abort_sub got %h exp %h", subSample_RnnnnU, NEW2_SUB); end
        ifc.req_valid = 4'hF;
        #1;
        checks++; if (ifc.req_ready !== 4'b0010) begin errors++; $display("FAIL abort_grant got %b exp 0010", ifc.req_ready); end
        tick();
        ifc.req_valid = 4'h0;
        tick();
        checks++; if (tri_count !== 32'd10) begin errors++; $display("FAIL abort_count got %0d exp 10", tri_count); end
    endtask

    task automatic test_reset_mid();
        ifc.req_valid = 4'hF;
        #1;
        checks++; if (ifc.req_ready !== 4'b0100) begin errors++; $display("FAIL rm_grant got %b exp 0100", ifc.req_ready); end
        tick();
        halt_RnnnnL = 1'b0;
        ifc.req_valid = 4'h0;
        cfg_valid = 1'b1;
        tick();
        checks++; if (validTri_R10H !== 1'b1) begin errors++; $display("FAIL rm_setup_valid got %b exp 1", validTri_R10H); end
        #2 rst = 1'b0;
        #1;
        checks++; if (validTri_R10H !== 1'b0) begin errors++; $display("FAIL rm_valid got %b exp 0", validTri_R10H); end
        checks++; if (tri_R10S !== '0) begin errors++; $display("FAIL rm_tri got %h exp 0", tri_R10S); end
        checks++; if (color_R10U !== '0) begin errors++; $display("FAIL rm_color got %h exp 0", color_R10U); end
        checks++; if (tri_count !== 32'd0) begin errors++; $display("FAIL rm_count got %0d exp 0", tri_count); end
        checks++; if (screen_RnnnnS !== DEF_SCR) begin errors++; $display("FAIL rm_screen got %h exp %h", screen_RnnnnS, DEF_SCR); end
        checks++; if (subSample_RnnnnU !== DEF_SUB) begin errors++; $display("FAIL rm_sub got %h exp %h", subSample_RnnnnU, DEF_SUB); end
        ifc.req_valid = 4'hF;
        #1;
        checks++; if (ifc.req_ready !== 4'b0) begin errors++; $display("FAIL rm_ready got %b exp 0000", ifc.req_ready); end
        cfg_valid = 1'b0;
        halt_RnnnnL = 1'b1;
        #1 rst = 1'b1;
        #1;
        checks++; if (ifc.req_ready !== 4'b0001) begin errors++; $display("FAIL rm_ptr_grant got %b exp 0001", ifc.req_ready); end
        tick();
        ifc.req_valid = 4'h0;
        tick();
        checks++; if (tri_count !== 32'd1) begin errors++; $display("FAIL rm_after_count got %0d exp 1", tri_count); end
    endtask

    task automatic test_wrap();
        force dut.count_q = 32'hFFFF_FFFF;
        #1 release dut.count_q;
        #1;
        checks++; if (tri_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preset got %h exp ffffffff", tri_count); end
        ifc.req_valid = 4'hF;
        #1;
        checks++; if (ifc.req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_grant got %b exp 0010", ifc.req_ready); end
        tick();
        ifc.req_valid = 4'h0;
        checks++; if (tri_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_hold got %h exp ffffffff", tri_count); end
        tick();
        checks++; if (tri_count !== 32'd0) begin errors++; $display("FAIL wrap_zero got %h exp 0", tri_count); end
        checks++; if (validTri_R10H !== 1'b0) begin errors++; $display("FAIL wrap_valid got %b exp 0", validTri_R10H); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stall();
        test_cfg();
        test_drain_halt();
        test_cfg_abort();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rast_dispatch.md
RAST_DISPATCH -- requirements
Module: rast_dispatch

Interface
REQ-001 SHALL have parameters: SIGFIG, default rast_params::SIGFIG, coordinate/color width; VERTS, default rast_params::VERTS, vertices; AXIS, default rast_params::AXIS, axes; COLORS, default rast_params::COLORS, channels; NREQ, default 4, triangle requesters; DRAIN_CYCLES, default rast_params::RAST_DRAIN, quiet cycles before config swap.
REQ-002 SHALL have one clock; reset asynchronous active-low: clk  in  1  clock; rst  in  1  async active-low reset.
REQ-003 SHALL have ports: req_tri_S  in  NREQ x VERTS x AXIS x SIGFIG signed  per-requester triangle; req_color_U  in  NREQ x COLORS x SIGFIG  per-requester color; req_valid  in  NREQ  offer; req_ready  out  NREQ  one-hot accept.
REQ-004 SHALL have ports: tri_R10S  out  VERTS x AXIS x SIGFIG signed  to rast; color_R10U  out  COLORS x SIGFIG  to rast; validTri_R10H  out  1  to rast; halt_RnnnnL  in  1  from rast, low = stalled.
REQ-005 SHALL have ports: cfg_screen_S  in  2 x SIGFIG signed  new screen size; cfg_subSample_U  in  4  new subsample; cfg_valid  in  1  config request; cfg_ready  out  1  one-cycle config ack; screen_RnnnnS  out  2 x SIGFIG  to rast; subSample_RnnnnU  out  4  to rast; tri_count  out  32  triangles delivered.

Function
REQ-006 SHALL hold one output triangle register (tri_R10S, color_R10U, validTri_R10H); transfer to rast occurs on a clk edge with validTri_R10H=1 and halt_RnnnnL=1.
REQ-007 SHALL compute load_en = state RUN and cfg_valid=0 and (validTri_R10H=0 or halt_RnnnnL=1); registered outputs stable while halt_RnnnnL=0.
REQ-008 SHALL grant round-robin: highest priority at pointer ptr, ascending mod NREQ; req_ready[i]=1 only for the granted i with req_valid[i]=1 and load_en=1 (combinational, at most one bit).
REQ-009 SHALL on grant load the output register with requester i data and set validTri_R10H=1 next edge (latency 1); set ptr to (i+1) mod NREQ.
REQ-010 SHALL on load_en=1 with no valid requester clear validTri_R10H; ptr unchanged.
REQ-011 SHALL increment tri_count on each transfer (REQ-006), wrapping 2^32-1 -> 0.
REQ-012 SHALL implement FSM RUN -> DRAIN -> CFG -> RUN.
REQ-013 RUN: cfg_valid=1 -> DRAIN next edge; no grants while cfg_valid=1 (config beats simultaneous requests).
REQ-014 DRAIN: quiet counter clears when validTri_R10H=1 or halt_RnnnnL=0, else increments; counter = DRAIN_CYCLES-1 and quiet -> CFG.
REQ-015 CFG: one cycle; cfg_ready=1; screen_RnnnnS<=cfg_screen_S, subSample_RnnnnU<=cfg_subSample_U; -> RUN; quiet counter cleared.
REQ-016 SHALL treat cfg_valid as level held until cfg_ready; cfg_valid dropping in DRAIN returns FSM to RUN with no config change.
REQ-017 SHALL NOT change screen_RnnnnS/subSample_RnnnnU outside CFG.

Reset
REQ-018 SHALL on rst=0 asynchronously: validTri_R10H=0, tri_R10S=0, color_R10U=0, ptr=0, state RUN, quiet counter 0, tri_count=0, cfg_ready=0, screen_RnnnnS=rast_params::DEF_SCREEN, subSample_RnnnnU=rast_params::DEF_SUBSAMPLE.
REQ-019 SHALL drop a triangle held mid-stall on reset; req_ready=0 while rst=0.

Structure
REQ-020 SHALL place RAST_DRAIN (= PIPES_BOX+PIPES_ITER+PIPES_HASH+PIPES_SAMP+8), NREQ default, DEF_SCREEN, DEF_SUBSAMPLE and the FSM state enum in rast_params.
REQ-021 SHALL implement arbitration as sub-module rr_arb (NREQ request in, one-hot grant out, pointer update input).

Verification
REQ-022 NREQ=4, req_valid=4'b1111 continuous, halt_RnnnnL=1 -> grants 0,1,2,3,0 on consecutive cycles, validTri_R10H one cycle after each.
REQ-023 Triangle in output register, halt_RnnnnL=0 for 5 cycles -> outputs unchanged, req_ready=0, tri_count unchanged; first halt-high edge -> tri_count+1.
REQ-024 cfg_valid=1 with requesters 1,3 valid; DRAIN_CYCLES=4 -> no grants; cfg_ready=1 exactly 4 quiet cycles after register empties; new screen/subsample visible next cycle; grants resume at ptr.
REQ-025 halt_RnnnnL pulses low during DRAIN after 3 quiet cycles -> counter restarts; CFG only after 4 further consecutive quiet cycles.
REQ-026 rst low while validTri_R10H=1 and state DRAIN -> all outputs at REQ-018 values immediately; tri_count=0.
REQ-027 tri_count preset near wrap (0xFFFFFFFF via 2^32-1 transfers or force) + one transfer -> 0.
